// File: rtl/saturating_counter_table_if.sv
// Read/update bus for saturating_counter_table: one registered read port and one update port.
interface saturating_counter_table_if #(
    parameter int WIDTH       = 2,
    parameter int INDEX_WIDTH = 4
);
    logic                   read_enable;
    logic [INDEX_WIDTH-1:0] read_index;
    logic                   read_valid;
    logic [WIDTH-1:0]       read_count;
    logic                   read_prediction;
    logic                   update_enable;
    logic [INDEX_WIDTH-1:0] update_index;
    logic                   update_increment;
    logic                   update_decrement;

    modport master (
        output read_enable, read_index,
        output update_enable, update_index, update_increment, update_decrement,
        input  read_valid, read_count, read_prediction
    );

    modport slave (
        input  read_enable, read_index,
        input  update_enable, update_index, update_increment, update_decrement,
        output read_valid, read_count, read_prediction
    );
endinterface

// File: rtl/saturating_counter_table.sv
// Indexed array of saturating up/down counters with a registered read port and an update port.
// Optional macro SATURATING_COUNTER_TABLE_BYPASS_EN forwards a same-cycle update to the read result.
module saturating_counter_table #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16,
    parameter int RESET = 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    saturating_counter_table_if.slave bus
);
    localparam int INDEX_WIDTH = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] count_t;

    localparam count_t                 COUNT_MAX   = '1;
    localparam count_t                 COUNT_ZERO  = '0;
    localparam count_t                 COUNT_RESET = count_t'(RESET);
    localparam logic [INDEX_WIDTH:0]   DEPTH_LIMIT = (INDEX_WIDTH + 1)'(DEPTH);

    count_t r_count [DEPTH];
    logic   r_read_valid;
    count_t r_read_count;

    logic   w_rd_hit;
    logic   w_upd_hit;
    count_t w_read_raw;
    count_t w_read_data;
    count_t w_upd_cur;
    count_t w_upd_next;

    // Indices at or above DEPTH are only reachable for non-power-of-two depths and address nothing.
    assign w_rd_hit  = bus.read_enable && ({1'b0, bus.read_index} < DEPTH_LIMIT);
    assign w_upd_hit = bus.update_enable && ({1'b0, bus.update_index} < DEPTH_LIMIT);

    assign w_read_raw = w_rd_hit  ? r_count[bus.read_index]   : COUNT_ZERO;
    assign w_upd_cur  = w_upd_hit ? r_count[bus.update_index] : COUNT_ZERO;

    // NOTE: always_comb assigns its output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_upd_next = w_upd_cur;
        if (bus.update_increment && !bus.update_decrement && (w_upd_cur != COUNT_MAX)) begin
            w_upd_next = w_upd_cur + 1'b1;
        end else if (bus.update_decrement && !bus.update_increment && (w_upd_cur != COUNT_ZERO)) begin
            w_upd_next = w_upd_cur - 1'b1;
        end
    end

`ifdef SATURATING_COUNTER_TABLE_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_rd_hit && w_upd_hit && (bus.read_index == bus.update_index);
    assign w_read_data = w_bypass ? w_upd_next : w_read_raw;
`else
    assign w_read_data = w_read_raw;
`endif

    // NOTE: the counter array is flip-flops, not RAM, so every entry is reset in one cycle.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_count[i] <= COUNT_RESET;
            end
        end else if (w_upd_hit) begin
            r_count[bus.update_index] <= w_upd_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_read_valid <= 1'b0;
            r_read_count <= COUNT_ZERO;
        end else begin
            r_read_valid <= bus.read_enable;
            if (bus.read_enable) begin
                r_read_count <= w_read_data;
            end
        end
    end

    assign bus.read_valid      = r_read_valid;
    assign bus.read_count      = r_read_count;
    assign bus.read_prediction = r_read_count[WIDTH-1];
endmodule

// File: tb/tb_saturating_counter_table.sv
// Directed self-checking bench for saturating_counter_table (DEPTH=16 and DEPTH=12 instances).
module tb_saturating_counter_table;
    localparam int W  = 2;
    localparam int IW = 4;

`ifdef SATURATING_COUNTER_TABLE_BYPASS_EN
    localparam logic [1:0] SAME_CYCLE_EXP = 2'd2;
`else
    localparam logic [1:0] SAME_CYCLE_EXP = 2'd1;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clock = ~clock;

    saturating_counter_table_if #(.WIDTH(W), .INDEX_WIDTH(IW)) bus16 ();
    saturating_counter_table_if #(.WIDTH(W), .INDEX_WIDTH(IW)) bus12 ();

    saturating_counter_table #(.WIDTH(2), .DEPTH(16), .RESET(1)) dut16 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus16)
    );

    saturating_counter_table #(.WIDTH(2), .DEPTH(12), .RESET(1)) dut12 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus12)
    );

    // Observations are packed as {read_valid, read_count, read_prediction}.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all;
        bus16.read_enable = 1'b0; bus16.read_index = '0;
        bus16.update_enable = 1'b0; bus16.update_index = '0;
        bus16.update_increment = 1'b0; bus16.update_decrement = 1'b0;
        bus12.read_enable = 1'b0; bus12.read_index = '0;
        bus12.update_enable = 1'b0; bus12.update_index = '0;
        bus12.update_increment = 1'b0; bus12.update_decrement = 1'b0;
    endtask

    task automatic obs16(output logic [3:0] obs);
        obs = {bus16.read_valid, bus16.read_count, bus16.read_prediction};
    endtask

    task automatic upd16(input int idx, input logic inc, input logic dec);
        bus16.update_enable = 1'b1; bus16.update_index = IW'(idx);
        bus16.update_increment = inc; bus16.update_decrement = dec;
        tick();
        bus16.update_enable = 1'b0; bus16.update_increment = 1'b0; bus16.update_decrement = 1'b0;
    endtask

    task automatic rd16(input int idx, output logic [3:0] obs);
        bus16.read_enable = 1'b1; bus16.read_index = IW'(idx);
        tick();
        bus16.read_enable = 1'b0;
        obs = {bus16.read_valid, bus16.read_count, bus16.read_prediction};
    endtask

    task automatic upd12(input int idx, input logic inc, input logic dec);
        bus12.update_enable = 1'b1; bus12.update_index = IW'(idx);
        bus12.update_increment = inc; bus12.update_decrement = dec;
        tick();
        bus12.update_enable = 1'b0; bus12.update_increment = 1'b0; bus12.update_decrement = 1'b0;
    endtask

    task automatic rd12(input int idx, output logic [3:0] obs);
        bus12.read_enable = 1'b1; bus12.read_index = IW'(idx);
        tick();
        bus12.read_enable = 1'b0;
        obs = {bus12.read_valid, bus12.read_count, bus12.read_prediction};
    endtask

    task automatic test_reset;
        logic [3:0] obs;
        resetn = 1'b0;
        bus16.read_enable = 1'b1; bus16.read_index = 4'd2;
        bus16.update_enable = 1'b1; bus16.update_index = 4'd2; bus16.update_increment = 1'b1;
        tick();
        tick();
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_00_0) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected %b", obs, 4'b0_00_0);
        end
        idle_all();
        resetn = 1'b1;
        tick();
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_00_0) begin
            n_bad++; $display("FAIL reset_idle: got %b expected %b", obs, 4'b0_00_0);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] obs;
        for (int i = 0; i < 16; i++) begin
            bus16.read_enable = 1'b1; bus16.read_index = IW'(i);
            tick();
            obs16(obs);
            n_cmp++;
            if (obs !== 4'b1_01_0) begin
                n_bad++; $display("FAIL b2b_read[%0d]: got %b expected %b", i, obs, 4'b1_01_0);
            end
        end
        bus16.read_enable = 1'b0;
        tick();
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_01_0) begin
            n_bad++; $display("FAIL b2b_valid_drop: got %b expected %b", obs, 4'b0_01_0);
        end
    endtask

    task automatic test_increment;
        logic [3:0] obs;
        logic [3:0] exp_seq [5] = '{4'b1_10_1, 4'b1_11_1, 4'b1_11_1, 4'b1_11_1, 4'b1_11_1};
        for (int i = 0; i < 5; i++) begin
            upd16(3, 1'b1, 1'b0);
            rd16(3, obs);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++; $display("FAIL inc_seq[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
        end
        rd16(2, obs);
        n_cmp++;
        if (obs !== 4'b1_01_0) begin
            n_bad++; $display("FAIL inc_neighbor2: got %b expected %b", obs, 4'b1_01_0);
        end
        rd16(4, obs);
        n_cmp++;
        if (obs !== 4'b1_01_0) begin
            n_bad++; $display("FAIL inc_neighbor4: got %b expected %b", obs, 4'b1_01_0);
        end
    endtask

    task automatic test_decrement;
        logic [3:0] obs;
        logic [3:0] exp_seq [5] = '{4'b1_10_1, 4'b1_01_0, 4'b1_00_0, 4'b1_00_0, 4'b1_00_0};
        for (int i = 0; i < 5; i++) begin
            upd16(3, 1'b0, 1'b1);
            rd16(3, obs);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++; $display("FAIL dec_seq[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [3:0] obs;
        upd12(13, 1'b1, 1'b0);
        upd12(12, 1'b1, 1'b0);
        upd12(15, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            rd12(i, obs);
            n_cmp++;
            if (obs !== 4'b1_01_0) begin
                n_bad++; $display("FAIL oor_entry[%0d]: got %b expected %b", i, obs, 4'b1_01_0);
            end
        end
        rd12(14, obs);
        n_cmp++;
        if (obs !== 4'b1_00_0) begin
            n_bad++; $display("FAIL oor_read: got %b expected %b", obs, 4'b1_00_0);
        end
    endtask

    task automatic test_both_neither;
        logic [3:0] obs;
        upd16(5, 1'b1, 1'b1);
        rd16(5, obs);
        n_cmp++;
        if (obs !== 4'b1_01_0) begin
            n_bad++; $display("FAIL both_set: got %b expected %b", obs, 4'b1_01_0);
        end
        upd16(5, 1'b0, 1'b0);
        rd16(5, obs);
        n_cmp++;
        if (obs !== 4'b1_01_0) begin
            n_bad++; $display("FAIL neither_set: got %b expected %b", obs, 4'b1_01_0);
        end
    endtask

    task automatic test_same_cycle;
        logic [3:0] obs;
        logic [3:0] exp_same;
        exp_same = {1'b1, SAME_CYCLE_EXP, SAME_CYCLE_EXP[1]};
        bus16.read_enable = 1'b1; bus16.read_index = 4'd7;
        upd16(7, 1'b1, 1'b0);
        bus16.read_enable = 1'b0;
        obs16(obs);
        n_cmp++;
        if (obs !== exp_same) begin
            n_bad++; $display("FAIL same_idx_read: got %b expected %b", obs, exp_same);
        end
        rd16(7, obs);
        n_cmp++;
        if (obs !== 4'b1_10_1) begin
            n_bad++; $display("FAIL same_idx_after: got %b expected %b", obs, 4'b1_10_1);
        end
        // Different indices in one cycle, then an update that must not touch the held result.
        bus16.read_enable = 1'b1; bus16.read_index = 4'd6;
        upd16(9, 1'b1, 1'b0);
        bus16.read_enable = 1'b0;
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b1_01_0) begin
            n_bad++; $display("FAIL diff_idx_read: got %b expected %b", obs, 4'b1_01_0);
        end
        upd16(6, 1'b1, 1'b0);
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_01_0) begin
            n_bad++; $display("FAIL held_after_update: got %b expected %b", obs, 4'b0_01_0);
        end
        rd16(6, obs);
        n_cmp++;
        if (obs !== 4'b1_10_1) begin
            n_bad++; $display("FAIL diff_idx_entry6: got %b expected %b", obs, 4'b1_10_1);
        end
        rd16(9, obs);
        n_cmp++;
        if (obs !== 4'b1_10_1) begin
            n_bad++; $display("FAIL diff_idx_entry9: got %b expected %b", obs, 4'b1_10_1);
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] obs;
        for (int k = 0; k < 2; k++) begin
            upd16(0, 1'b1, 1'b0);
            upd16(8, 1'b1, 1'b0);
            upd16(15, 1'b1, 1'b0);
        end
        rd16(15, obs);
        n_cmp++;
        if (obs !== 4'b1_11_1) begin
            n_bad++; $display("FAIL pre_reset_entry15: got %b expected %b", obs, 4'b1_11_1);
        end
        resetn = 1'b0;
        bus16.read_enable = 1'b1; bus16.read_index = 4'd8;
        tick();
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_00_0) begin
            n_bad++; $display("FAIL mid_reset_drop: got %b expected %b", obs, 4'b0_00_0);
        end
        resetn = 1'b1;
        bus16.read_enable = 1'b0;
        tick();
        obs16(obs);
        n_cmp++;
        if (obs !== 4'b0_00_0) begin
            n_bad++; $display("FAIL mid_reset_next: got %b expected %b", obs, 4'b0_00_0);
        end
        for (int i = 0; i < 16; i++) begin
            rd16(i, obs);
            n_cmp++;
            if (obs !== 4'b1_01_0) begin
                n_bad++; $display("FAIL post_reset_entry[%0d]: got %b expected %b", i, obs, 4'b1_01_0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_back_to_back();
        test_increment();
        test_decrement();
        test_out_of_range();
        test_both_neither();
        test_same_cycle();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
